// File: rtl/inst_mem_bank_if.sv
// Fetch and load port bundle for the instruction memory bank.
// Neither port handshakes: the master samples instr the cycle after it presents pc,
// holds it with stall, and gates its loads only on ready.
interface inst_mem_bank_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
);
    logic [PC_W-1:0]   pc;
    logic              stall;
    logic [DATA_W-1:0] instr;
    logic              fetch_valid;
    logic              ready;
    logic              ld_en;
    logic [PC_W-1:0]   ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_err;

    modport master (
        output pc, stall, ld_en, ld_addr, ld_data,
        input  instr, fetch_valid, ready, ld_err
    );

    modport slave (
        input  pc, stall, ld_en, ld_addr, ld_data,
        output instr, fetch_valid, ready, ld_err
    );
endinterface

// File: rtl/inst_mem_bank.sv
// Loadable word-addressed instruction store for the fetch stage.
// It clears itself to NOP after reset, reads with one registered cycle, and forwards same-cycle loads.
module inst_mem_bank #(
    parameter int                 DATA_W   = 16,
    parameter int                 DEPTH    = 64,
    parameter int                 AW       = $clog2(DEPTH),
    parameter int                 PC_W     = 16,
    parameter int                 PC_SHIFT = 2,
    parameter int                 LIMIT    = DEPTH,
    parameter logic [DATA_W-1:0]  NOP_WORD = 16'b0000100000000000
) (
    input  logic           clk,
    input  logic           rst,
    inst_mem_bank_if.slave bus,
    output logic           dbg_state
);
    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t            state;
    logic [AW-1:0]     clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] instr_q;
    logic              fetch_valid_q;
    logic              ready_q;
    logic              ld_err_q;

    logic [PC_W-1:0]   idx;
    logic              idx_ok;
    logic              ld_ok;
    logic              ld_go;
    logic              fwd;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] fetch_word;

    // The limit compare uses the full shifted pc, so high pcs cannot alias onto low words.
    assign idx        = bus.pc >> PC_SHIFT;
    assign idx_ok     = idx < PC_W'(LIMIT);
    assign ld_ok      = {1'b0, bus.ld_addr} < (PC_W + 1)'(DEPTH);
    assign ld_go      = (state == RUN) && bus.ld_en && ld_ok;
    assign fwd        = ld_go && (bus.ld_addr == idx);
    assign rd_word    = mem[idx[AW-1:0]];
    assign fetch_word = !idx_ok ? NOP_WORD : (fwd ? bus.ld_data : rd_word);

    // The storage array has no reset, so holding rst low leaves its contents alone.
    always_ff @(posedge clk) begin
        if (rst && (state == INIT)) begin
            mem[clr_cnt] <= NOP_WORD;
        end else if (ld_go) begin
            mem[bus.ld_addr[AW-1:0]] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= INIT;
            clr_cnt       <= '0;
            instr_q       <= NOP_WORD;
            fetch_valid_q <= 1'b0;
            ready_q       <= 1'b0;
            ld_err_q      <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(DEPTH - 1)) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.stall) begin
                        instr_q       <= fetch_word;
                        fetch_valid_q <= 1'b1;
                    end
                    ld_err_q <= bus.ld_en && !ld_ok;
                end
                default: state <= INIT;
            endcase
        end
    end

    assign bus.instr       = instr_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.ready       = ready_q;
    assign bus.ld_err      = ld_err_q;
    assign dbg_state       = state;
endmodule

// File: tb/tb_inst_mem_bank.sv
// Directed bench for inst_mem_bank: clear timing, fetch and load paths, limit, collision, stall and reset.
module tb_inst_mem_bank;
  localparam logic [15:0] NOP = 16'h0800;

  logic clk;
  logic rst;
  logic dbg;
  logic dbg4;

  int n_cmp;
  int n_bad;
  logic [15:0] exp_q[$];

  inst_mem_bank_if #(.DATA_W(16), .PC_W(16)) bus ();
  inst_mem_bank_if #(.DATA_W(16), .PC_W(16)) bus4 ();

  assign bus4.pc      = bus.pc;
  assign bus4.stall   = bus.stall;
  assign bus4.ld_en   = bus.ld_en;
  assign bus4.ld_addr = bus.ld_addr;
  assign bus4.ld_data = bus.ld_data;

  inst_mem_bank u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg)
  );

  inst_mem_bank #(.LIMIT(4)) u_lim (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus4),
    .dbg_state (dbg4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] addr, input logic [15:0] data);
    bus.ld_en   = 1'b1;
    bus.ld_addr = addr;
    bus.ld_data = data;
    tick();
    bus.ld_en   = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [15:0] pc_v, input logic [15:0] exp);
    bus.pc = pc_v;
    exp_q.push_back(exp);
    tick();
    check(tag, bus.instr, exp_q.pop_front());
    check({tag, "_v"}, bus.fetch_valid, 1);
  endtask

  // Counts edges from release until ready; a missing ready shows as a wrong count.
  task automatic clear_len(input string tag, output int n);
    n = 0;
    while (!bus.ready && n < 200) begin
      tick();
      n++;
    end
    check(tag, n, 64);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_instr"}, bus.instr, NOP);
    check({tag, "_fv"}, bus.fetch_valid, 0);
    check({tag, "_rdy"}, bus.ready, 0);
    check({tag, "_err"}, bus.ld_err, 0);
  endtask

  initial begin
    int n;
    logic err_seen;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.pc = '0;
    bus.stall = 1'b0;
    bus.ld_en = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = '0;

    tick();
    check_reset_vals("rst");
    check("rst_state", dbg, 0);
    rst = 1'b1;

    // Loads during the clear must be ignored without error.
    bus.ld_en = 1'b1;
    bus.ld_data = 16'hFFFF;
    n = 0;
    err_seen = 1'b0;
    while (!bus.ready && n < 200) begin
      bus.ld_addr = (n < 32) ? 16'd0 : 16'd70;
      if (n == 63) check("init_instr", bus.instr, NOP);
      tick();
      n++;
      err_seen = err_seen | bus.ld_err;
    end
    bus.ld_en = 1'b0;
    check("clear_len", n, 64);
    check("init_err", err_seen, 0);
    check("init_fv", bus.fetch_valid, 0);
    check("run_state", dbg, 1);

    for (int i = 0; i < 64; i++) fetch($sformatf("sweep%0d", i), 16'(i * 4), NOP);

    load(16'd1, 16'h69BF);
    load(16'd2, 16'h3120);
    fetch("ld_pc4", 16'd4, 16'h69BF);
    fetch("ld_pc8", 16'd8, 16'h3120);

    load(16'd5, 16'hDB44);
    fetch("full_pc20", 16'd20, 16'hDB44);
    check("lim_pc20", bus4.instr, NOP);
    fetch("full_pc104", 16'h0104, NOP);
    check("lim_pc104", bus4.instr, NOP);
    bus.pc = 16'd4;
    tick();
    check("lim_pc4", bus4.instr, 16'h69BF);

    // Same-cycle load and fetch of one word returns the new data.
    bus.ld_en = 1'b1;
    bus.ld_addr = 16'd3;
    bus.ld_data = 16'h9940;
    fetch("coll", 16'd12, 16'h9940);
    bus.ld_en = 1'b0;
    check("coll_err", bus.ld_err, 0);

    load(16'd64, 16'hBEEF);
    check("bad_err", bus.ld_err, 1);
    tick();
    check("bad_err_clr", bus.ld_err, 0);
    load(16'd65, 16'hBEEF);
    check("bad2_err", bus.ld_err, 1);
    load(16'd6, 16'hA5A5);
    check("good_clears_err", bus.ld_err, 0);
    fetch("bad_nowrite", 16'd0, NOP);
    fetch("good_ld", 16'd24, 16'hA5A5);

    fetch("stall_pre", 16'd4, 16'h69BF);
    bus.stall = 1'b1;
    bus.pc = 16'd8;
    load(16'd1, 16'h1234);
    check("stall_hold0", bus.instr, 16'h69BF);
    for (int i = 1; i < 3; i++) begin
      tick();
      check($sformatf("stall_hold%0d", i), bus.instr, 16'h69BF);
    end
    bus.stall = 1'b0;
    fetch("stall_rel", 16'd8, 16'h3120);
    fetch("stall_ld", 16'd4, 16'h1234);

    // Async reset in RUN, then again partway through the clear.
    rst = 1'b0;
    #1;
    check_reset_vals("run_rst");
    #1;
    rst = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    check("mid_init_rdy", bus.ready, 0);
    rst = 1'b0;
    #1;
    check_reset_vals("init_rst");
    #1;
    rst = 1'b1;
    clear_len("reclear_len", n);
    fetch("lost_pc4", 16'd4, NOP);
    fetch("lost_pc8", 16'd8, NOP);
    fetch("lost_pc12", 16'd12, NOP);
    fetch("lost_pc20", 16'd20, NOP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
